// File: rtl/kernel_launcher_pkg.sv
// rtl/kernel_launcher_pkg.sv - shared state encoding and parameter defaults for the kernel launcher
package kernel_launcher_pkg;

    localparam int DATAW_DEFAULT   = 32;
    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        S_Idle   = 2'd0,
        S_Launch = 2'd1,
        S_Wait   = 2'd2,
        S_Hold   = 2'd3
    } state_t;

    // A one-cycle timeout would still need a 1-bit counter.
    function automatic int count_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/launch_timer.sv
// rtl/launch_timer.sv - clearable saturating cycle counter with terminal-count flag
module launch_timer
    import kernel_launcher_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CW      = count_width(TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Holding at LAST keeps the count from wrapping while a kernel is outstanding.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign done = (count == LAST);

endmodule

// File: rtl/kernel_launcher.sv
// rtl/kernel_launcher.sv - operand capture, kernel start/complete handshake, result hold and error tracking
module kernel_launcher
    import kernel_launcher_pkg::*;
#(
    parameter int DATAW   = DATAW_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [DATAW-1:0] InA,
    input  logic [DATAW-1:0] InB,
    input  logic [DATAW-1:0] InC,
    output logic [DATAW-1:0] a,
    output logic [DATAW-1:0] b,
    output logic [DATAW-1:0] c,
    output logic             CStart,
    input  logic             CEnd,
    input  logic [DATAW-1:0] z,
    input  logic [DATAW-1:0] x,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [DATAW-1:0] OutZ,
    output logic [DATAW-1:0] OutX,
    output logic             Error,
    input  logic             ErrorRst
);

    state_t state;
    logic   accept;
    logic   tmr_done;
    logic   spurious;
    logic   timed_out;

    assign InReady   = (state == S_Idle);
    assign accept    = InReady && InValid;
    assign spurious  = CEnd && (state != S_Wait);
    assign timed_out = (state == S_Wait) && !CEnd && tmr_done;

    // Counter reads 0 during the CStart cycle, so it tracks cycles elapsed since CStart.
    launch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk  (Clk),
        .rst  (Rst),
        .clr  (accept),
        .en   ((state == S_Launch) || (state == S_Wait)),
        .done (tmr_done)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= S_Idle;
            CStart   <= 1'b0;
            OutValid <= 1'b0;
            Error    <= 1'b0;
            a        <= '0;
            b        <= '0;
            c        <= '0;
            OutZ     <= '0;
            OutX     <= '0;
        end else begin
            CStart <= 1'b0;
            case (state)
                S_Idle: begin
                    if (InValid) begin
                        a      <= InA;
                        b      <= InB;
                        c      <= InC;
                        CStart <= 1'b1;
                        state  <= S_Launch;
                    end
                end
                S_Launch: begin
                    state <= S_Wait;
                end
                S_Wait: begin
                    // A completion on the terminal cycle still counts as on time.
                    if (CEnd) begin
                        OutZ     <= z;
                        OutX     <= x;
                        OutValid <= 1'b1;
                        state    <= S_Hold;
                    end else if (tmr_done) begin
                        state <= S_Idle;
                    end
                end
                S_Hold: begin
                    if (OutReady) begin
                        OutValid <= 1'b0;
                        state    <= S_Idle;
                    end
                end
                default: begin
                    state <= S_Idle;
                end
            endcase

            if (spurious || timed_out) begin
                Error <= 1'b1;
            end else if (ErrorRst) begin
                Error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kernel_launcher.sv
// tb/tb_kernel_launcher.sv - self-checking bench for kernel_launcher
module tb_kernel_launcher;

    localparam int DATAW   = 32;
    localparam int TIMEOUT = 16;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             InValid;
    logic             InReady;
    logic [DATAW-1:0] InA, InB, InC;
    logic [DATAW-1:0] a, b, c;
    logic             CStart;
    logic             CEnd;
    logic [DATAW-1:0] z, x;
    logic             OutValid;
    logic             OutReady;
    logic [DATAW-1:0] OutZ, OutX;
    logic             Error;
    logic             ErrorRst;

    logic             kernel_en;
    logic             k_cend = 1'b0;
    logic [DATAW-1:0] k_z = '0, k_x = '0;
    logic             m_cend;
    logic [DATAW-1:0] m_z, m_x;

    assign CEnd = kernel_en ? k_cend : m_cend;
    assign z    = kernel_en ? k_z : m_z;
    assign x    = kernel_en ? k_x : m_x;

    kernel_launcher #(
        .DATAW   (DATAW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .InValid  (InValid),
        .InReady  (InReady),
        .InA      (InA),
        .InB      (InB),
        .InC      (InC),
        .a        (a),
        .b        (b),
        .c        (c),
        .CStart   (CStart),
        .CEnd     (CEnd),
        .z        (z),
        .x        (x),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutZ     (OutZ),
        .OutX     (OutX),
        .Error    (Error),
        .ErrorRst (ErrorRst)
    );

    always #5 Clk = ~Clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        else passed++;
    endtask

    function automatic logic [DATAW-1:0] ref_z(input logic [DATAW-1:0] ra, input logic [DATAW-1:0] rb);
        return (ra + rb) / rb;
    endfunction

    function automatic logic [DATAW-1:0] ref_x(input logic [DATAW-1:0] rb, input logic [DATAW-1:0] rc);
        return rc + rb * rb;
    endfunction

    // Kernel model: completes 6 cycles after the cycle CStart is high.
    int               kdelay = 0;
    logic [DATAW-1:0] ka, kb, kc;
    always @(negedge Clk) begin
        k_cend = 1'b0;
        if (kdelay > 0) begin
            kdelay--;
            if (kdelay == 0) begin
                k_cend = 1'b1;
                k_z    = ref_z(ka, kb);
                k_x    = ref_x(kb, kc);
            end
        end
        if (CStart && kernel_en) begin
            kdelay = 6;
            ka     = a;
            kb     = b;
            kc     = c;
        end
    end

    logic [63:0] sb[$];
    logic [63:0] sb_exp;
    int          cstart_cnt = 0;
    always @(posedge Clk) begin
        if (!Rst && CStart) cstart_cnt++;
        if (!Rst && InValid && InReady) sb.push_back({ref_z(InA, InB), ref_x(InB, InC)});
        if (!Rst && OutValid && OutReady) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_result", 1, 0);
            end else begin
                sb_exp = sb.pop_front();
                check("sb_result", {OutZ, OutX}, sb_exp);
            end
        end
    end

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic wait_out_valid(output int n, output logic prev_cend);
        n = 0;
        prev_cend = 1'b0;
        while (!OutValid && n < 40) begin
            prev_cend = CEnd;
            tick();
            n++;
        end
        check("out_valid_seen", OutValid, 1);
    endtask

    typedef struct {
        logic [DATAW-1:0] ia, ib, ic;
        logic [DATAW-1:0] ez, ex;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n;
        int   c0;
        logic prev;
        logic ov_seen;

        vecs[0] = '{ia: 5,   ib: 3, ic: 7, ez: 2,  ex: 16};
        vecs[1] = '{ia: 4,   ib: 2, ic: 2, ez: 3,  ex: 6};
        vecs[2] = '{ia: 10,  ib: 5, ic: 1, ez: 3,  ex: 26};
        vecs[3] = '{ia: 100, ib: 7, ic: 9, ez: 15, ex: 58};
        vecs[4] = '{ia: 0,   ib: 1, ic: 0, ez: 1,  ex: 1};

        Rst = 1'b1; InValid = 1'b0; InA = '0; InB = '0; InC = '0;
        OutReady = 1'b1; ErrorRst = 1'b0; kernel_en = 1'b1;
        m_cend = 1'b0; m_z = '0; m_x = '0;
        repeat (3) tick();
        check("rst_in_ready", InReady, 1);
        check("rst_cstart", CStart, 0);
        check("rst_out_valid", OutValid, 0);
        check("rst_error", Error, 0);
        check("rst_abc", {a, b, c}, 0);
        check("rst_out_zx", {OutZ, OutX}, 0);
        Rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            InA = vecs[i].ia; InB = vecs[i].ib; InC = vecs[i].ic; InValid = 1'b1;
            check("vec_in_ready_idle", InReady, 1);
            c0 = cstart_cnt;
            tick();
            InValid = 1'b0;
            check("vec_cstart_t1", CStart, 1);
            check("vec_in_ready_busy", InReady, 0);
            check("vec_abc_capture", {a, b, c}, {vecs[i].ia, vecs[i].ib, vecs[i].ic});
            wait_out_valid(n, prev);
            check("vec_cend_to_valid", prev, 1);
            check("vec_cstart_to_valid", n, 7);
            check("vec_out_z", OutZ, vecs[i].ez);
            check("vec_out_x", OutX, vecs[i].ex);
            tick();
            check("vec_out_valid_clear", OutValid, 0);
            check("vec_one_cstart", cstart_cnt - c0, 1);
            check("vec_no_error", Error, 0);
        end

        // Kernel never completes: timeout after 16 cycles.
        kernel_en = 1'b0;
        InA = 9; InB = 3; InC = 1; InValid = 1'b1;
        tick();
        InValid = 1'b0;
        check("to_cstart", CStart, 1);
        n = 0; ov_seen = 1'b0;
        while (!Error && n < 40) begin
            ov_seen |= OutValid;
            tick();
            n++;
        end
        check("to_cycles", n, 16);
        check("to_idle", InReady, 1);
        check("to_no_out_valid", {ov_seen, OutValid}, 0);
        if (sb.size() > 0) void'(sb.pop_front());
        tick();
        check("to_error_sticky", Error, 1);
        ErrorRst = 1'b1;
        tick();
        ErrorRst = 1'b0;
        check("to_error_cleared", Error, 0);

        // Completion on the terminal cycle wins over timeout.
        InA = 20; InB = 4; InC = 3; InValid = 1'b1;
        tick();
        InValid = 1'b0;
        check("edge_cstart", CStart, 1);
        repeat (14) tick();
        check("edge_no_early_error", Error, 0);
        tick();
        m_z = ref_z(20, 4); m_x = ref_x(4, 3); m_cend = 1'b1;
        tick();
        m_cend = 1'b0;
        check("edge_out_valid", OutValid, 1);
        check("edge_error_clear", Error, 0);
        check("edge_out_zx", {OutZ, OutX}, {32'd6, 32'd19});
        tick();
        check("edge_out_valid_clear", OutValid, 0);

        // Back-pressure: result held while OutReady is low.
        kernel_en = 1'b1;
        OutReady = 1'b0;
        InA = 5; InB = 3; InC = 7; InValid = 1'b1;
        tick();
        InValid = 1'b0;
        wait_out_valid(n, prev);
        InA = 4; InB = 2; InC = 2; InValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_in_ready", InReady, 0);
            check("hold_out_zx", {OutValid, OutZ, OutX}, {1'b1, 32'd2, 32'd16});
        end
        OutReady = 1'b1;
        tick();
        check("hold_release_idle", {InReady, OutValid}, 2'b10);
        tick();
        InValid = 1'b0;
        check("hold_next_accept", CStart, 1);
        wait_out_valid(n, prev);
        check("hold_next_zx", {OutZ, OutX}, {32'd3, 32'd6});
        tick();

        // Spurious completion while idle.
        kernel_en = 1'b0;
        m_z = 32'hdead; m_x = 32'hbeef; m_cend = 1'b1;
        tick();
        m_cend = 1'b0;
        check("spur_error", Error, 1);
        check("spur_state", {InReady, OutValid}, 2'b10);
        check("spur_out_unchanged", {OutZ, OutX}, {32'd3, 32'd6});
        m_cend = 1'b1; ErrorRst = 1'b1;
        tick();
        m_cend = 1'b0;
        check("spur_set_wins", Error, 1);
        tick();
        ErrorRst = 1'b0;
        check("spur_cleared", Error, 0);

        // Reset while waiting on the kernel, then a late completion.
        kernel_en = 1'b1;
        InA = 8; InB = 2; InC = 5; InValid = 1'b1;
        tick();
        InValid = 1'b0;
        check("rw_cstart", CStart, 1);
        repeat (3) tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        sb.delete();
        check("rw_ctrl_reset", {InReady, CStart, OutValid, Error}, 4'b1000);
        check("rw_abc_reset", {a, b, c}, 0);
        check("rw_out_reset", {OutZ, OutX}, 0);
        n = 0;
        while (!CEnd && n < 20) begin
            tick();
            n++;
        end
        check("rw_late_cend_seen", CEnd, 1);
        tick();
        check("rw_late_cend_error", {Error, OutValid}, 2'b10);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
